// File: rtl/device_uart_tx_pkg.sv
// Shared constants for the device-bus UART transmitter: register offsets,
// STATUS bit positions and the transmit state encoding.
package device_uart_tx_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_TXDATA  = 3'd1;
    localparam logic [2:0] REG_DIVISOR = 3'd2;
    localparam logic [2:0] REG_CONTROL = 3'd3;
    localparam logic [2:0] REG_OWNER   = 3'd4;

    localparam int STATUS_OVERFLOW = 0;
    localparam int STATUS_FULL     = 1;
    localparam int STATUS_EMPTY    = 2;
    localparam int STATUS_BUSY     = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [15:0] status_word(input logic busy, input logic empty,
                                                input logic full, input logic overflow);
        logic [15:0] word;
        word                  = 16'h0000;
        word[STATUS_BUSY]     = busy;
        word[STATUS_EMPTY]    = empty;
        word[STATUS_FULL]     = full;
        word[STATUS_OVERFLOW] = overflow;
        return word;
    endfunction

endpackage

// File: rtl/device_uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted when
// a pop happens in the same cycle.
module sync_fifo
    import device_uart_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == CNT_W'(0));
    assign full      = (count_r == CNT_W'(DEPTH));
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage array; contents need no reset since the pointers qualify them.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/device_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus writes queue bytes into a FIFO,
// a bit-timed FSM shifts them out LSB first on uart_tx.
module device_uart_tx
    import device_uart_tx_pkg::*;
#(
    parameter logic [9:0]  BASE_ADDR       = 10'h000,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  device_core_id,
    input  logic        device_write_en,
    input  logic        device_read_en,
    input  logic [9:0]  device_addr,
    input  logic [15:0] device_data_out,
    output logic [15:0] device_data_in,
    output logic        uart_tx
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             select_s;
    logic [2:0]       offset_s;
    logic             wr_sel_s;
    logic             rd_sel_s;
    logic             push_req_s;
    logic             push_ok_s;
    logic             ovf_set_s;
    logic             ovf_clr_s;
    logic             fifo_pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [7:0]       fifo_dout_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [15:0]      rd_mux_s;
    logic             bit_end_s;

    logic [15:0]      divisor_r;
    logic             overflow_r;
    logic [3:0]       owner_r;
    logic [15:0]      rd_data_r;

    tx_state_e        state_r;
    tx_state_e        state_nx;
    logic [2:0]       bit_cnt_r;
    logic [2:0]       bit_cnt_nx;
    logic [15:0]      baud_cnt_r;
    logic [15:0]      baud_cnt_nx;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nx;
    logic             tx_r;
    logic             tx_nx;

    assign select_s   = (device_addr[9:3] == BASE_ADDR[9:3]);
    assign offset_s   = device_addr[2:0];
    assign wr_sel_s   = device_write_en && select_s;
    assign rd_sel_s   = device_read_en && select_s;
    assign push_req_s = wr_sel_s && (offset_s == REG_TXDATA);
    // A push into a full FIFO survives only if the transmitter pops this cycle.
    assign push_ok_s  = push_req_s && (!fifo_full_s || fifo_pop_s);
    assign ovf_set_s  = push_req_s && fifo_full_s && !fifo_pop_s;
    assign ovf_clr_s  = wr_sel_s && (offset_s == REG_CONTROL) && device_data_out[0];
    assign bit_end_s  = (baud_cnt_r == 16'h0000);

    assign device_data_in = rd_data_r;
    assign uart_tx        = tx_r;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req_s),
        .push_data (device_data_out[7:0]),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_dout_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Read-data mux over the pre-edge register values.
    always_comb begin
        rd_mux_s = 16'h0000;
        case (offset_s)
            REG_STATUS:  rd_mux_s = status_word(state_r != TX_IDLE, fifo_empty_s,
                                                fifo_full_s, overflow_r);
            REG_DIVISOR: rd_mux_s = divisor_r;
            REG_CONTROL: rd_mux_s = 16'(fifo_count_s);
            REG_OWNER:   rd_mux_s = {12'h000, owner_r};
            default:     rd_mux_s = 16'h0000;
        endcase
    end

    // Bus-visible registers and the one-cycle read-return register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divisor_r  <= DEFAULT_DIVISOR;
            overflow_r <= 1'b0;
            owner_r    <= 4'h0;
            rd_data_r  <= 16'h0000;
        end else begin
            if (wr_sel_s && (offset_s == REG_DIVISOR)) begin
                divisor_r <= device_data_out;
            end
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr_s) begin
                overflow_r <= 1'b0;
            end
            if (push_ok_s) begin
                owner_r <= device_core_id;
            end
            rd_data_r <= rd_sel_s ? rd_mux_s : 16'h0000;
        end
    end

    // Transmit FSM next-state: every bit reloads the divisor and ends when the count reads 0.
    always_comb begin
        state_nx    = state_r;
        bit_cnt_nx  = bit_cnt_r;
        baud_cnt_nx = baud_cnt_r;
        shift_nx    = shift_r;
        tx_nx       = tx_r;
        fifo_pop_s  = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s  = 1'b1;
                    shift_nx    = fifo_dout_s;
                    baud_cnt_nx = divisor_r;
                    tx_nx       = 1'b0;
                    state_nx    = TX_START;
                end else begin
                    tx_nx = 1'b1;
                end
            end
            TX_START: begin
                if (bit_end_s) begin
                    state_nx    = TX_DATA;
                    bit_cnt_nx  = 3'd0;
                    baud_cnt_nx = divisor_r;
                    tx_nx       = shift_r[0];
                end else begin
                    baud_cnt_nx = baud_cnt_r - 16'd1;
                end
            end
            TX_DATA: begin
                if (bit_end_s) begin
                    baud_cnt_nx = divisor_r;
                    if (bit_cnt_r == 3'd7) begin
                        state_nx = TX_STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        bit_cnt_nx = bit_cnt_r + 3'd1;
                        shift_nx   = {1'b0, shift_r[7:1]};
                        tx_nx      = shift_r[1];
                    end
                end else begin
                    baud_cnt_nx = baud_cnt_r - 16'd1;
                end
            end
            TX_STOP: begin
                if (bit_end_s) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty_s) begin
                        fifo_pop_s  = 1'b1;
                        shift_nx    = fifo_dout_s;
                        baud_cnt_nx = divisor_r;
                        tx_nx       = 1'b0;
                        state_nx    = TX_START;
                    end else begin
                        tx_nx    = 1'b1;
                        state_nx = TX_IDLE;
                    end
                end else begin
                    baud_cnt_nx = baud_cnt_r - 16'd1;
                end
            end
            default: begin
                state_nx = TX_IDLE;
                tx_nx    = 1'b1;
            end
        endcase
    end

    // Transmit FSM state register; reset drives the line idle-high at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= TX_IDLE;
            bit_cnt_r  <= 3'd0;
            baud_cnt_r <= 16'h0000;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
        end else begin
            state_r    <= state_nx;
            bit_cnt_r  <= bit_cnt_nx;
            baud_cnt_r <= baud_cnt_nx;
            shift_r    <= shift_nx;
            tx_r       <= tx_nx;
        end
    end

endmodule

// File: tb/tb_device_uart_tx.sv
// Self-checking bench for device_uart_tx: register table, frame timing,
// back-to-back/overflow, divisor change mid-bit and reset mid-frame.
`timescale 1ns/1ps
module tb_device_uart_tx;

    localparam logic [9:0] BASE = 10'h120;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  device_core_id;
    logic        device_write_en;
    logic        device_read_en;
    logic [9:0]  device_addr;
    logic [15:0] device_data_out;
    logic [15:0] device_data_in;
    logic        uart_tx;

    int checks   = 0;
    int failures = 0;

    logic log_en = 1'b0;
    logic tx_log [$];
    logic exp_q  [$];

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [0:19];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (log_en) tx_log.push_back(uart_tx);
    end

    device_uart_tx #(
        .BASE_ADDR       (BASE),
        .FIFO_DEPTH      (8),
        .DEFAULT_DIVISOR (16'd433)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .device_core_id  (device_core_id),
        .device_write_en (device_write_en),
        .device_read_en  (device_read_en),
        .device_addr     (device_addr),
        .device_data_out (device_data_out),
        .device_data_in  (device_data_in),
        .uart_tx         (uart_tx)
    );

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [15:0] data, input logic [3:0] core);
        device_write_en = 1'b1;
        device_addr     = BASE + {7'd0, off};
        device_data_out = data;
        device_core_id  = core;
        tick();
        device_write_en = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [2:0] off, input logic [15:0] exp);
        device_read_en = 1'b1;
        device_addr    = BASE + {7'd0, off};
        tick();
        device_read_en = 1'b0;
        check16(name, device_data_in, exp);
    endtask

    task automatic push_bits(input logic v, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(v);
    endtask

    task automatic push_frame(input logic [7:0] b, input int n);
        push_bits(1'b0, n);
        for (int k = 0; k < 8; k++) push_bits(b[k], n);
        push_bits(1'b1, n);
    endtask

    task automatic restart_log();
        log_en = 1'b0;
        tx_log.delete();
        log_en = 1'b1;
    endtask

    // Align on the first low sample, then compare exp_q followed by 'tail' idle-high samples.
    task automatic check_stream(input string name, input int tail);
        int   start;
        int   bad;
        logic e;
        start = -1;
        bad   = -1;
        for (int i = 0; i < tx_log.size(); i++) begin
            if (start < 0 && tx_log[i] == 1'b0) start = i;
        end
        checks++;
        if (start < 0 || tx_log.size() < start + exp_q.size() + tail) begin
            failures++;
            $display("FAIL %s no start bit or short capture: size=%0d start=%0d required=%0d",
                     name, tx_log.size(), start, exp_q.size() + tail);
        end else begin
            for (int i = 0; i < exp_q.size() + tail; i++) begin
                e = (i < exp_q.size()) ? exp_q[i] : 1'b1;
                if (bad < 0 && tx_log[start + i] !== e) bad = i;
            end
            if (bad >= 0) begin
                failures++;
                e = (bad < exp_q.size()) ? exp_q[bad] : 1'b1;
                $display("FAIL %s sample %0d after start: actual=%b expected=%b",
                         name, bad, tx_log[start + bad], e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int          zeros;
        logic [7:0]  pat;

        reset           = 1'b0;
        device_core_id  = 4'h0;
        device_write_en = 1'b0;
        device_read_en  = 1'b0;
        device_addr     = 10'h000;
        device_data_out = 16'h0000;

        vecs[0]  = '{1'b0, 1'b1, BASE + 10'd0, 16'h0000, 16'h0004};
        vecs[1]  = '{1'b0, 1'b0, BASE + 10'd0, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, BASE + 10'd2, 16'h0000, 16'd433};
        vecs[3]  = '{1'b0, 1'b1, BASE + 10'd4, 16'h0000, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, BASE + 10'd3, 16'h0000, 16'h0000};
        vecs[5]  = '{1'b0, 1'b1, BASE + 10'd1, 16'h0000, 16'h0000};
        vecs[6]  = '{1'b1, 1'b0, BASE + 10'd6, 16'hFFFF, 16'h0000};
        vecs[7]  = '{1'b0, 1'b1, BASE + 10'd6, 16'h0000, 16'h0000};
        vecs[8]  = '{1'b0, 1'b1, BASE + 10'd7, 16'h0000, 16'h0000};
        vecs[9]  = '{1'b1, 1'b0, BASE + 10'd2, 16'd100,  16'h0000};
        vecs[10] = '{1'b0, 1'b1, BASE + 10'd2, 16'h0000, 16'd100};
        vecs[11] = '{1'b1, 1'b0, 10'h12A,      16'd5,    16'h0000};
        vecs[12] = '{1'b0, 1'b1, 10'h11A,      16'h0000, 16'h0000};
        vecs[13] = '{1'b0, 1'b1, BASE + 10'd2, 16'h0000, 16'd100};
        vecs[14] = '{1'b1, 1'b1, BASE + 10'd2, 16'd200,  16'd100};
        vecs[15] = '{1'b0, 1'b1, BASE + 10'd2, 16'h0000, 16'd200};
        vecs[16] = '{1'b1, 1'b0, BASE + 10'd2, 16'd433,  16'h0000};
        vecs[17] = '{1'b0, 1'b1, BASE + 10'd2, 16'h0000, 16'd433};
        vecs[18] = '{1'b1, 1'b0, BASE + 10'd3, 16'h0001, 16'h0000};
        vecs[19] = '{1'b0, 1'b1, BASE + 10'd0, 16'h0000, 16'h0004};

        repeat (3) tick();
        check16("reset_uart_tx", {15'd0, uart_tx}, 16'h0001);
        check16("reset_data_in", device_data_in, 16'h0000);
        reset = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 20; i++) begin
            device_write_en = vecs[i].wr;
            device_read_en  = vecs[i].rd;
            device_addr     = vecs[i].addr;
            device_data_out = vecs[i].wdata;
            tick();
            device_write_en = 1'b0;
            device_read_en  = 1'b0;
            check16($sformatf("vec%0d", i), device_data_in, vecs[i].exp_data);
        end
        check16("idle_line", {15'd0, uart_tx}, 16'h0001);

        // One 0x55 frame at 4 cycles per bit from core 5.
        bus_write(3'd2, 16'd3, 4'd0);
        restart_log();
        bus_write(3'd1, 16'h0055, 4'd5);
        repeat (10) tick();
        read_check("status_busy", 3'd0, 16'h000C);
        repeat (45) tick();
        read_check("status_after_frame", 3'd0, 16'h0004);
        read_check("owner_core5", 3'd4, 16'd5);
        exp_q.delete();
        push_frame(8'h55, 4);
        check_stream("frame_55", 8);

        // Ten back-to-back pushes at 1 cycle per bit; the tenth finds a full FIFO.
        bus_write(3'd2, 16'd0, 4'd0);
        restart_log();
        for (int i = 1; i <= 10; i++) bus_write(3'd1, 16'h00A0 + 16'(i), 4'(i));
        read_check("status_full_ovf", 3'd0, 16'h000B);
        read_check("count_full", 3'd3, 16'd8);
        bus_write(3'd3, 16'h0001, 4'd0);
        read_check("status_ovf_cleared", 3'd0, 16'h0008);
        read_check("owner_last_accepted", 3'd4, 16'd9);
        repeat (100) tick();
        read_check("status_drained", 3'd0, 16'h0004);
        exp_q.delete();
        for (int i = 1; i <= 9; i++) push_frame(8'hA0 + 8'(i), 1);
        check_stream("b2b_frames", 10);

        // Divisor 3 -> 7 written in the middle of data bit 0.
        bus_write(3'd2, 16'd3, 4'd0);
        restart_log();
        bus_write(3'd1, 16'h0055, 4'd2);
        tick();
        check16("divchg_start_low", {15'd0, uart_tx}, 16'h0000);
        repeat (4) tick();
        bus_write(3'd2, 16'd7, 4'd0);
        repeat (80) tick();
        read_check("divisor_7", 3'd2, 16'd7);
        pat = 8'h55;
        exp_q.delete();
        push_bits(1'b0, 4);
        push_bits(pat[0], 4);
        for (int k = 1; k < 8; k++) push_bits(pat[k], 8);
        push_bits(1'b1, 8);
        check_stream("divisor_change", 4);

        // Reset during data bit 3 of the first of five zero bytes.
        bus_write(3'd2, 16'd3, 4'd0);
        for (int i = 0; i < 5; i++) bus_write(3'd1, 16'h0000, 4'(i));
        repeat (14) tick();
        check16("bit3_low_before_reset", {15'd0, uart_tx}, 16'h0000);
        reset = 1'b0;
        #1;
        check16("async_reset_tx_high", {15'd0, uart_tx}, 16'h0001);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        read_check("status_after_reset", 3'd0, 16'h0004);
        read_check("divisor_after_reset", 3'd2, 16'd433);
        read_check("count_after_reset", 3'd3, 16'd0);
        restart_log();
        repeat (60) tick();
        zeros = 0;
        for (int i = 0; i < tx_log.size(); i++) if (tx_log[i] == 1'b0) zeros++;
        check16("no_frames_after_reset", 16'(zeros), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
